// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared defaults and next-PC source encodings for pc_redirect_unit.
package pc_redirect_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  localparam int FLUSH_CYCLES_DEF = 2;
  typedef enum logic [1:0] {PC_SEQ, PC_TGT, PC_TRAP, PC_HOLD} pc_src_e;
  typedef enum logic {IDLE, FLUSH} state_e;
endpackage

// File: rtl/pc_redirect_unit_next_pc_mux.sv
// pc_redirect_unit_next_pc_mux: target adders, alignment check and next-PC select (RVC_EN relaxes alignment).
module pc_redirect_unit_next_pc_mux
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic        busy,
  input  logic        stall,
  input  logic        branch,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic [31:0] exPC,
  input  logic [31:0] exImm,
  input  logic [31:0] exRs1,
  input  logic        ifCompressed,
  output logic [31:0] target,
  output pc_src_e     src,
  output logic [31:0] pc_next
);
  logic req, mis;
  logic [31:0] step;
`ifndef RVC_EN
  logic unused_rvc;
  assign unused_rvc = ifCompressed;
`endif
  always_comb begin
    req = ((branch & branchTaken) | jump | jumpReg) & ~busy;
    target = jumpReg ? ((exRs1 + exImm) & ~32'h1) : exPC + exImm;
`ifdef RVC_EN
    mis = target[0];
    step = ifCompressed ? 32'd2 : 32'd4;
`else
    mis = |target[1:0];
    step = 32'd4;
`endif
    src = req ? (mis ? PC_TRAP : PC_TGT) : stall ? PC_HOLD : PC_SEQ;
    pc_next = src == PC_TRAP ? TRAP_VEC : src == PC_TGT ? target : src == PC_HOLD ? pc : pc + step;
  end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register, redirect/trap pulses and post-redirect flush FSM (RVC_EN enables compressed steps).
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic [31:0] exPC,
  input  logic [31:0] exImm,
  input  logic [31:0] exRs1,
  input  logic        ifCompressed,
  output logic [31:0] pc,
  output logic [31:0] pcNext,
  output logic        flush,
  output logic        redirect,
  output logic        misalignTrap,
  output logic [31:0] misalignAddr
);
  state_e state;
  logic [2:0] cnt;
  logic [31:0] target;
  pc_src_e src;
  logic redir;
  pc_redirect_unit_next_pc_mux #(.TRAP_VEC(TRAP_VEC)) u_mux (
    .pc(pc), .busy(flush), .stall(stall), .branch(branch), .branchTaken(branchTaken),
    .jump(jump), .jumpReg(jumpReg), .exPC(exPC), .exImm(exImm), .exRs1(exRs1),
    .ifCompressed(ifCompressed), .target(target), .src(src), .pc_next(pcNext)
  );
  assign redir = src == PC_TGT || src == PC_TRAP;
  // flush mirrors state; requests are masked by it so no redirect can occur while flushing
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= IDLE;
      cnt <= '0;
      flush <= 1'b0;
      redirect <= 1'b0;
      misalignTrap <= 1'b0;
      misalignAddr <= '0;
    end else begin
      pc <= pcNext;
      redirect <= redir;
      misalignTrap <= src == PC_TRAP;
      if (src == PC_TRAP) misalignAddr <= target;
      if (redir) begin
        state <= FLUSH;
        cnt <= 3'(FLUSH_CYCLES);
        flush <= 1'b1;
      end else if (state == FLUSH) begin
        cnt <= cnt - 3'd1;
        flush <= cnt != 3'd1;
        state <= cnt == 3'd1 ? IDLE : FLUSH;
      end
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plus random stimulus, reference model feeding a scoreboard queue.
module tb_pc_redirect_unit;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] TRAP = 32'h100;
  localparam int FC = 2;
`ifdef RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  logic clk = 1'b0, rst, stall, branch, branchTaken, jump, jumpReg, ifCompressed;
  logic [31:0] exPC, exImm, exRs1, pc, pcNext, misalignAddr;
  logic flush, redirect, misalignTrap;
  typedef struct {
    logic [31:0] pc;
    logic fl, rd, tr;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;
  int m_busy = 0;
  logic [31:0] m_pc = 0, m_addr = 0;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branchTaken(branchTaken),
    .jump(jump), .jumpReg(jumpReg), .exPC(exPC), .exImm(exImm), .exRs1(exRs1),
    .ifCompressed(ifCompressed), .pc(pc), .pcNext(pcNext), .flush(flush),
    .redirect(redirect), .misalignTrap(misalignTrap), .misalignAddr(misalignAddr)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
  endtask

  task automatic clr();
    {stall, branch, branchTaken, jump, jumpReg, ifCompressed} = '0;
    exPC = 0; exImm = 0; exRs1 = 0;
  endtask

  // one clock of stimulus: advance the model, check pcNext, queue expected registered outputs
  task automatic step();
    exp_t e;
    logic [31:0] tgt;
    bit take, bad;
    if (rst) begin
      m_pc = RST_PC; m_busy = 0; m_addr = 0; e.rd = 0; e.tr = 0;
    end else begin
      take = m_busy == 0 && ((branch && branchTaken) || jump || jumpReg);
      tgt = jumpReg ? exRs1 + exImm : exPC + exImm;
      if (jumpReg) tgt = tgt - (tgt % 2);
      bad = RVC ? (tgt % 2 != 0) : (tgt % 4 != 0);
      e.rd = take; e.tr = take && bad;
      if (take) begin
        m_pc = bad ? TRAP : tgt;
        if (bad) m_addr = tgt;
        m_busy = FC;
      end else begin
        if (m_busy > 0) m_busy--;
        if (!stall) m_pc = m_pc + ((RVC && ifCompressed) ? 2 : 4);
      end
      #1 chk("pcNext", pcNext, m_pc);
    end
    e.pc = m_pc; e.fl = m_busy != 0; e.addr = m_addr;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("flush", 32'(flush), 32'(e.fl));
        chk("redirect", 32'(redirect), 32'(e.rd));
        chk("misalignTrap", 32'(misalignTrap), 32'(e.tr));
        chk("misalignAddr", misalignAddr, e.addr);
      end
    end
  end

  initial begin
    clr(); rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    repeat (4) step();
    exPC = 32'h40; exImm = 32'h20; branch = 1; branchTaken = 1; step();
    clr(); repeat (3) step();
    jumpReg = 1; exRs1 = 32'h1001; exImm = 32'h10; step();
    clr(); jump = 1; exPC = 32'h40; exImm = 32'h100; step();
    clr(); repeat (2) step();
    exPC = 32'h40; exImm = 32'h22; branch = 1; branchTaken = 1; step();
    clr(); repeat (3) step();
    stall = 1; jump = 1; exPC = 32'h100; exImm = 32'h100; step();
    jump = 0; repeat (5) step();
    clr(); jump = 1; exImm = 32'h300; step();
    clr(); rst = 1; step();
    rst = 0; repeat (2) step();
    ifCompressed = 1; repeat (3) step();
    clr(); exImm = 32'hFFFF_FFFC - m_pc; jump = 1; step();
    clr(); repeat (3) step();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      stall = $urandom_range(0, 3) == 0;
      branch = $urandom_range(0, 3) == 0;
      branchTaken = $urandom_range(0, 1) == 1;
      jump = $urandom_range(0, 7) == 0;
      jumpReg = $urandom_range(0, 7) == 0;
      ifCompressed = $urandom_range(0, 1) == 1;
      exPC = $urandom & 32'hFFFF_FFFE;
      exImm = 32'($signed(12'($urandom)));
      exRs1 = $urandom;
      step();
    end
    clr(); rst = 0;
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
